// File: rtl/vend_pkg.sv
// Shared constants and state encoding for the vend dispense controller.
package vend_pkg;

  localparam int unsigned CHG_W      = 2;
  localparam int unsigned DIME       = 1;
  localparam int unsigned LOW_THRESH = 3;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD      = 3'd1,
    ST_PAPER     = 3'd2,
    ST_PAPER_REL = 3'd3,
    ST_COIN      = 3'd4,
    ST_COIN_REL  = 3'd5
  } state_e;

endpackage

// File: rtl/vend_evt_fifo.sv
// Pending vend-event FIFO: first-word-fall-through read, registered full/empty.
module vend_evt_fifo
  import vend_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = CHG_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] wdata_i,
  output logic [W-1:0] rdata_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic          full_q, empty_q;
  logic          do_push, do_pop;

  // A push while full is refused even if a pop frees a slot this cycle.
  assign do_push = push_i && !full_q;
  assign do_pop  = pop_i && !empty_q;

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + (AW + 1)'(1);
    end else if (!do_push && do_pop) begin
      count_d = count_q - (AW + 1)'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
      full_q  <= (count_d == (AW + 1)'(DEPTH));
      empty_q <= (count_d == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;

endmodule

// File: rtl/vend_dispense_ctrl.sv
// Turns queued vend events into paper/coin req-ack handshakes and tracks the
// dime inventory with sticky overflow/shortage flags.
module vend_dispense_ctrl
  import vend_pkg::*;
#(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned CNT_W     = 6,
  parameter int unsigned COIN_INIT = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             vend_valid,
  input  logic [CHG_W-1:0] vend_chg,
  output logic             vend_ready,
  output logic             paper_req,
  input  logic             paper_ack,
  output logic             coin_req,
  input  logic             coin_ack,
  input  logic             reload,
  input  logic [CNT_W-1:0] reload_cnt,
  output logic [CNT_W-1:0] coin_cnt,
  output logic             low_change,
  output logic             busy,
  output logic             ovf_err,
  output logic             short_err
);

  state_e           state_q, state_d;
  logic [CHG_W-1:0] remaining_q, remaining_d, fifo_data;
  logic [CNT_W-1:0] coin_cnt_q, coin_cnt_d;
  logic             paper_req_q, paper_req_d, coin_req_q, coin_req_d;
  logic             ovf_q, ovf_d, short_q, short_d;
  logic             fifo_full, fifo_empty, push, pop;
  logic             coin_take, coin_short;
  state_e           after_rel;

  assign push       = vend_valid && !fifo_full;
  assign pop        = (state_q == ST_LOAD);
  assign coin_take  = (state_q == ST_COIN) && coin_req_q && coin_ack;
  // COIN entered without a request means the inventory was empty on entry.
  assign coin_short = (state_q == ST_COIN) && !coin_req_q;
  assign after_rel  = fifo_empty ? ST_IDLE : ST_LOAD;

  vend_evt_fifo #(.DEPTH(DEPTH), .W(CHG_W)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (vend_chg),
    .rdata_o (fifo_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:      if (!fifo_empty) state_d = ST_LOAD;
      ST_LOAD:      state_d = ST_PAPER;
      ST_PAPER:     if (paper_ack) state_d = ST_PAPER_REL;
      ST_PAPER_REL: if (!paper_ack) state_d = (remaining_q != '0) ? ST_COIN : after_rel;
      ST_COIN: begin
        if (coin_short)    state_d = ST_IDLE;
        else if (coin_ack) state_d = ST_COIN_REL;
      end
      ST_COIN_REL:  if (!coin_ack) state_d = (remaining_q != '0) ? ST_COIN : after_rel;
      default:      state_d = ST_IDLE;
    endcase
  end

  // Requests are registered from the next state; coin_req is decided once on COIN entry.
  always_comb begin
    paper_req_d = (state_d == ST_PAPER);
    coin_req_d  = 1'b0;
    if (state_d == ST_COIN) begin
      coin_req_d = (state_q == ST_COIN) ? coin_req_q : (coin_cnt_d != '0);
    end
  end

  always_comb begin
    remaining_d = remaining_q;
    if (pop)             remaining_d = fifo_data;
    else if (coin_take)  remaining_d = remaining_q - CHG_W'(1);
    else if (coin_short) remaining_d = '0;

    coin_cnt_d = coin_cnt_q;
    if (reload && coin_take) begin
      coin_cnt_d = (reload_cnt == '0) ? '0 : reload_cnt - CNT_W'(DIME);
    end else if (reload) begin
      coin_cnt_d = reload_cnt;
    end else if (coin_take && coin_cnt_q != '0) begin
      coin_cnt_d = coin_cnt_q - CNT_W'(DIME);
    end

    ovf_d   = ovf_q || (vend_valid && fifo_full);
    short_d = short_q || coin_short;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      remaining_q <= '0;
      coin_cnt_q  <= CNT_W'(COIN_INIT);
      paper_req_q <= 1'b0;
      coin_req_q  <= 1'b0;
      ovf_q       <= 1'b0;
      short_q     <= 1'b0;
    end else begin
      remaining_q <= remaining_d;
      coin_cnt_q  <= coin_cnt_d;
      paper_req_q <= paper_req_d;
      coin_req_q  <= coin_req_d;
      ovf_q       <= ovf_d;
      short_q     <= short_d;
    end
  end

  assign vend_ready = !fifo_full;
  assign paper_req  = paper_req_q;
  assign coin_req   = coin_req_q;
  assign coin_cnt   = coin_cnt_q;
  assign low_change = (coin_cnt_q < CNT_W'(LOW_THRESH));
  assign busy       = (state_q != ST_IDLE) || !fifo_empty;
  assign ovf_err    = ovf_q;
  assign short_err  = short_q;

endmodule

// File: tb/tb_vend_dispense_ctrl.sv
// Scoreboard bench: expected dispense sequence queued at push time, checked by a monitor.
module tb_vend_dispense_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       vend_valid = 1'b0;
  logic [1:0] vend_chg = 2'd0;
  logic       vend_ready, paper_req, coin_req, low_change, busy, ovf_err, short_err;
  logic       paper_ack = 1'b0, coin_ack = 1'b0, reload = 1'b0;
  logic [5:0] reload_cnt = 6'd0;
  logic [5:0] coin_cnt;

  int checks = 0, failures = 0;
  int exp_q[$];                 // 0 = paper, 1 = coin, in dispense order
  int inv = 20;                 // model dime inventory as scheduled at push time
  int exp_short = 0, exp_ovf = 0;
  int pushed = 0, papers_seen = 0;
  bit stall_paper = 0, stall_coin = 0, reload_pend = 0, ackrel_pend = 0, spur_pend = 0;
  int reload_val = 0, ackrel_val = 0, cfg_lat = -1;

  vend_dispense_ctrl dut (
    .clk(clk), .rst(rst), .vend_valid(vend_valid), .vend_chg(vend_chg),
    .vend_ready(vend_ready), .paper_req(paper_req), .paper_ack(paper_ack),
    .coin_req(coin_req), .coin_ack(coin_ack), .reload(reload), .reload_cnt(reload_cnt),
    .coin_cnt(coin_cnt), .low_change(low_change), .busy(busy),
    .ovf_err(ovf_err), .short_err(short_err)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  function automatic void check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endfunction

  function automatic int next_lat();
    return (cfg_lat >= 0) ? cfg_lat : int'($urandom_range(0, 3));
  endfunction

  // Each event: one paper, then as many dimes as the inventory still covers.
  function automatic void model_add(input int c);
    int n;
    n = (c < inv) ? c : inv;
    exp_q.push_back(0);
    repeat (n) exp_q.push_back(1);
    inv -= n;
    if (n < c) exp_short = 1;
    pushed++;
  endfunction

  // Dispenser model: drives acks, reloads and spurious pulses on negedges.
  initial begin
    int p_wait = 0, c_wait = 0, p_lat = 0, c_lat = 0;
    forever begin
      @(negedge clk);
      reload = 1'b0;
      if (reload_pend) begin
        reload = 1'b1; reload_cnt = 6'(reload_val); reload_pend = 0;
      end
      if (spur_pend) begin
        paper_ack = 1'b1; coin_ack = 1'b1; spur_pend = 0;
      end else begin
        if (paper_ack) begin
          if (!paper_req) paper_ack = 1'b0;
        end else if (paper_req && !stall_paper) begin
          if (p_wait >= p_lat) begin
            paper_ack = 1'b1; p_wait = 0; p_lat = next_lat();
          end else p_wait++;
        end
        if (coin_ack) begin
          if (!coin_req) coin_ack = 1'b0;
        end else if (coin_req && !stall_coin) begin
          if (c_wait >= c_lat) begin
            coin_ack = 1'b1; c_wait = 0; c_lat = next_lat();
            if (ackrel_pend) begin
              reload = 1'b1; reload_cnt = 6'(ackrel_val); ackrel_pend = 0;
            end
          end else c_wait++;
        end
      end
    end
  end

  // Monitor: every new request must be the next expected dispense item.
  initial begin
    logic pr_prev = 1'b0, cr_prev = 1'b0;
    int kind;
    forever begin
      @(negedge clk);
      if (rst) exp_q.delete();
      else begin
        if (paper_req && !pr_prev) begin
          papers_seen++;
          check("paper_expected", int'(exp_q.size() != 0), 1);
          if (exp_q.size() != 0) begin kind = exp_q.pop_front(); check("disp_kind", 0, kind); end
          check("req_excl", int'(coin_req), 0);
        end
        if (coin_req && !cr_prev) begin
          check("coin_expected", int'(exp_q.size() != 0), 1);
          if (exp_q.size() != 0) begin kind = exp_q.pop_front(); check("disp_kind", 1, kind); end
          check("coin_inv_nonzero", int'(coin_cnt != 6'd0), 1);
        end
      end
      pr_prev = paper_req;
      cr_prev = coin_req;
    end
  end

  // Called at a negedge; returns at the negedge after the sampling edge.
  task automatic push_evt(input int c, input bit acc);
    vend_valid = 1'b1;
    vend_chg   = 2'(c);
    if (acc) model_add(c); else exp_ovf = 1;
    @(negedge clk);
    vend_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    do begin @(negedge clk); n++; end
    while (!(!busy && exp_q.size() == 0 && !paper_ack && !coin_ack) && n < 3000);
    @(negedge clk);
    check({name, "_idle"}, int'(n < 3000), 1);
    check({name, "_cnt"}, int'(coin_cnt), inv);
    check({name, "_low"}, int'(low_change), int'(inv < 3));
    check({name, "_short"}, int'(short_err), exp_short);
    check({name, "_ovf"}, int'(ovf_err), exp_ovf);
  endtask

  task automatic wait_high(input string name, input bit coin);
    int n = 0;
    while (((coin ? coin_req : paper_req) == 1'b0) && n < 200) begin @(negedge clk); n++; end
    check({name, "_timeout"}, int'(n < 200), 1);
  endtask

  task automatic do_reload(input int v);
    reload_val = v; reload_pend = 1;
    repeat (2) @(negedge clk);
    inv = v;
    check("reload_cnt", int'(coin_cnt), v);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_paper_req", int'(paper_req), 0);
    check("rst_coin_req", int'(coin_req), 0);
    check("rst_ready", int'(vend_ready), 1);
    check("rst_coin_cnt", int'(coin_cnt), 20);
    check("rst_busy", int'(busy), 0);
    check("rst_low", int'(low_change), 0);
    check("rst_errs", int'({ovf_err, short_err}), 0);
    rst = 1'b0;
    @(negedge clk);

    // Single event: paper_req rises exactly after the second edge past the push.
    cfg_lat = 3;
    push_evt(2, 1);
    check("lat_k", int'(paper_req), 0);
    @(negedge clk); check("lat_k1", int'(paper_req), 0);
    @(negedge clk); check("lat_k2", int'(paper_req), 1);
    wait_idle("single");
    check("single_18", int'(coin_cnt), 18);
    cfg_lat = -1;

    // Spurious acks while idle change nothing.
    spur_pend = 1;
    repeat (3) @(negedge clk);
    check("spur_busy", int'(busy), 0);
    check("spur_reqs", int'({paper_req, coin_req}), 0);
    check("spur_cnt", int'(coin_cnt), 18);

    // Overflow: FSM held in PAPER, four queue, fifth dropped.
    stall_paper = 1;
    push_evt(1, 1);
    wait_high("ovf_first", 1'b0);
    push_evt(0, 1); push_evt(1, 1); push_evt(2, 1); push_evt(3, 1); push_evt(3, 0);
    check("ovf_ready", int'(vend_ready), 0);
    check("ovf_flag", int'(ovf_err), 1);
    stall_paper = 0;
    wait_idle("ovf");
    check("ovf_ready_back", int'(vend_ready), 1);

    // Reload coinciding with a coin decrement.
    do_reload(10);
    ackrel_val = 7; ackrel_pend = 1;
    push_evt(1, 1);
    inv = ackrel_val - 1;
    wait_idle("reload_ack");

    // Randomized traffic with random ack latencies.
    do_reload(63);
    for (int i = 0; i < 30; i++) begin
      int n = 0;
      repeat ($urandom_range(0, 4)) @(negedge clk);
      while (pushed - papers_seen >= 4 && n < 500) begin @(negedge clk); n++; end
      check("rand_ready", int'(vend_ready), 1);
      push_evt(int'($urandom_range(0, 3)), 1);
    end
    wait_idle("random");

    // Shortage: one dime in stock, three owed.
    do_reload(1);
    push_evt(3, 1);
    wait_idle("short");
    check("short_flag", int'(short_err), 1);
    check("short_low", int'(low_change), 1);

    // Reset mid coin handshake with events queued.
    do_reload(5);
    stall_coin = 1;
    push_evt(3, 1);
    wait_high("rst_coin", 1'b1);
    push_evt(1, 1); push_evt(2, 1);
    rst = 1'b1;
    #1;
    check("rst_mid_coin_req", int'(coin_req), 0);
    check("rst_mid_cnt", int'(coin_cnt), 20);
    check("rst_mid_ready", int'(vend_ready), 1);
    check("rst_mid_errs", int'({ovf_err, short_err}), 0);
    stall_coin = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    inv = 20; exp_short = 0; exp_ovf = 0;
    repeat (3) @(negedge clk);
    check("rst_rel_busy", int'(busy), 0);
    push_evt(1, 1);
    wait_idle("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
